// File: rtl/traffic_pkg.sv
// Shared encodings for the pedestrian traffic-light controller.
// Contents: the phase/state enum (the value is driven directly on the phase port)
// and the phase port width.
package traffic_pkg;

  localparam int unsigned PHASE_W = 2;

  typedef enum logic [PHASE_W-1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_FLASH  = 2'd3
  } phase_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into one-cycle phase ticks.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset, clears the counter
//   clr   - restart the count at a phase boundary
//   tick  - high on the last cycle of each TICK_DIV-cycle period
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider, restarted at every phase entry
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/ped_traffic_ctrl.sv
// Single-junction traffic-light controller with latched pedestrian requests,
// early green termination and a fault-driven flashing-yellow mode.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   ped_req             - pedestrian button (level or pulse)
//   fault               - level; forces flashing-yellow while high
//   red, yellow, green  - lamp drives
//   walk, dont_walk     - pedestrian signals (complementary)
//   ped_ack             - one-cycle pulse when a request is latched
//   phase               - 0=RED 1=GREEN 2=YELLOW 3=FLASH
//   remaining           - ticks left in phase minus 1 (0 in FLASH)
module ped_traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned RED_T       = 10,
  parameter int unsigned GREEN_T     = 8,
  parameter int unsigned YELLOW_T    = 3,
  parameter int unsigned MIN_GREEN_T = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ped_req,
  input  logic               fault,
  output logic               red,
  output logic               yellow,
  output logic               green,
  output logic               walk,
  output logic               dont_walk,
  output logic               ped_ack,
  output logic [PHASE_W-1:0] phase,
  output logic [CNT_W-1:0]   remaining
);

  localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_T - 1);
  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_T - 1);
  // Timer value at or below which MIN_GREEN_T ticks have elapsed (counting the current tick)
  localparam logic [CNT_W:0]   GREEN_CUT   = (CNT_W+1)'(GREEN_T - MIN_GREEN_T);

  phase_t           state, nxt_state;
  logic [CNT_W-1:0] nxt_timer;
  logic             pending, nxt_pending;
  logic             flash, nxt_flash;
  logic             ack_set;
  logic             clr;
  logic             tick;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  // Next-state, timer, pedestrian latch and flash-bit logic
  always_comb begin
    nxt_state   = state;
    nxt_timer   = remaining;
    nxt_pending = pending;
    nxt_flash   = flash;
    ack_set     = 1'b0;
    clr         = 1'b0;
    if (fault) begin
      // Fault overrides everything, including a simultaneous request or expiry
      nxt_state   = PH_FLASH;
      nxt_timer   = '0;
      nxt_pending = 1'b0;
      if (state != PH_FLASH) begin
        clr       = 1'b1;
        nxt_flash = 1'b1;
      end else if (tick) begin
        nxt_flash = ~flash;
      end
    end else begin
      if (ped_req && !pending && (state == PH_GREEN || state == PH_YELLOW)) begin
        nxt_pending = 1'b1;
        ack_set     = 1'b1;
      end
      case (state)
        PH_RED: begin
          if (tick) begin
            if (remaining == '0) begin
              nxt_state = PH_GREEN;
              nxt_timer = GREEN_LOAD;
              clr       = 1'b1;
            end else begin
              nxt_timer = remaining - CNT_W'(1);
            end
          end
        end
        PH_GREEN: begin
          if (tick) begin
            if (remaining == '0 || (pending && {1'b0, remaining} <= GREEN_CUT)) begin
              nxt_state = PH_YELLOW;
              nxt_timer = YELLOW_LOAD;
              clr       = 1'b1;
            end else begin
              nxt_timer = remaining - CNT_W'(1);
            end
          end
        end
        PH_YELLOW: begin
          if (tick) begin
            if (remaining == '0) begin
              // A request latched on this same cycle is served by the RED we enter
              nxt_state   = PH_RED;
              nxt_timer   = RED_LOAD;
              nxt_pending = 1'b0;
              clr         = 1'b1;
            end else begin
              nxt_timer = remaining - CNT_W'(1);
            end
          end
        end
        PH_FLASH: begin
          nxt_state   = PH_RED;
          nxt_timer   = RED_LOAD;
          nxt_pending = 1'b0;
          nxt_flash   = 1'b0;
          clr         = 1'b1;
        end
        default: nxt_state = PH_RED;
      endcase
    end
  end

  // State register with outputs decoded from the next state so they track it without lag
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PH_RED;
      remaining <= RED_LOAD;
      pending   <= 1'b0;
      flash     <= 1'b0;
      red       <= 1'b1;
      yellow    <= 1'b0;
      green     <= 1'b0;
      walk      <= 1'b1;
      dont_walk <= 1'b0;
      ped_ack   <= 1'b0;
      phase     <= PH_RED;
    end else begin
      state     <= nxt_state;
      remaining <= nxt_timer;
      pending   <= nxt_pending;
      flash     <= nxt_flash;
      red       <= (nxt_state == PH_RED);
      yellow    <= (nxt_state == PH_YELLOW) || (nxt_state == PH_FLASH && nxt_flash);
      green     <= (nxt_state == PH_GREEN);
      walk      <= (nxt_state == PH_RED);
      dont_walk <= (nxt_state != PH_RED);
      ped_ack   <= ack_set;
      phase     <= nxt_state;
    end
  end

endmodule

// File: tb/tb_ped_traffic_ctrl.sv
// Self-checking bench for ped_traffic_ctrl: directed scenarios followed by
// random stimulus, every cycle compared against a cycle-count based model.
module tb_ped_traffic_ctrl;

  localparam int TD   = 4;
  localparam int CW   = 8;
  localparam int RT   = 6;
  localparam int GT   = 8;
  localparam int YT   = 2;
  localparam int MINT = 3;

  logic clk = 1'b0;
  logic reset, ped_req, fault;
  logic red, yellow, green, walk, dont_walk, ped_ack;
  logic [1:0]    phase;
  logic [CW-1:0] remaining;

  int tests = 0;
  int failed = 0;

  // Reference model: phase number, cycles since phase entry, pending, ack
  int   m_ph = 0;
  int   m_cyc = 0;
  bit   m_pend = 0;
  bit   m_ack = 0;

  // Run-length tracker of observed phases
  int   prev_ph = 0;
  int   run = 0;
  int   last_len [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  ped_traffic_ctrl #(
    .TICK_DIV(TD), .CNT_W(CW), .RED_T(RT), .GREEN_T(GT),
    .YELLOW_T(YT), .MIN_GREEN_T(MINT)
  ) dut (
    .clk(clk), .reset(reset), .ped_req(ped_req), .fault(fault),
    .red(red), .yellow(yellow), .green(green), .walk(walk),
    .dont_walk(dont_walk), .ped_ack(ped_ack), .phase(phase),
    .remaining(remaining)
  );

  function automatic int dur(input int ph);
    case (ph)
      0: return RT;
      1: return GT;
      default: return YT;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge with the sampled inputs
  task automatic model_step(input bit r, input bit f, input bit p);
    int  ticks;
    bit  at_tick, done, pend_n;
    if (r) begin
      m_ph = 0; m_cyc = 0; m_pend = 0; m_ack = 0;
    end else if (f) begin
      m_ack = 0;
      if (m_ph != 3) begin
        m_ph = 3; m_cyc = 0; m_pend = 0;
      end else begin
        m_cyc++;
      end
    end else if (m_ph == 3) begin
      m_ack = 0; m_ph = 0; m_cyc = 0; m_pend = 0;
    end else begin
      m_ack   = p && !m_pend && (m_ph == 1 || m_ph == 2);
      pend_n  = m_pend || m_ack;
      ticks   = m_cyc / TD + 1;
      at_tick = (m_cyc % TD) == TD - 1;
      done    = at_tick && (ticks == dur(m_ph) || (m_ph == 1 && m_pend && ticks >= MINT));
      if (done) begin
        m_ph  = (m_ph + 1) % 3;
        m_cyc = 0;
        if (m_ph == 0) pend_n = 0;
      end else begin
        m_cyc++;
      end
      m_pend = pend_n;
    end
  endtask

  task automatic check_all();
    int ex_rem;
    bit ex_yel;
    ex_rem = (m_ph == 3) ? 0 : dur(m_ph) - 1 - m_cyc / TD;
    ex_yel = (m_ph == 2) || (m_ph == 3 && ((m_cyc / TD) % 2 == 0));
    chk("phase", 32'(phase), m_ph);
    chk("red", 32'(red), 32'(m_ph == 0));
    chk("green", 32'(green), 32'(m_ph == 1));
    chk("yellow", 32'(yellow), 32'(ex_yel));
    chk("walk", 32'(walk), 32'(m_ph == 0));
    chk("dont_walk", 32'(dont_walk), 32'(m_ph != 0));
    chk("ped_ack", 32'(ped_ack), 32'(m_ack));
    chk("remaining", 32'(remaining), ex_rem);
    if (int'(phase) != prev_ph) begin
      last_len[prev_ph] = run;
      run = 1;
      prev_ph = int'(phase);
    end else begin
      run++;
    end
  endtask

  task automatic step(input bit r, input bit f, input bit p);
    reset = r; fault = f; ped_req = p;
    @(posedge clk);
    model_step(r, f, p);
    #1;
    check_all();
  endtask

  // Step with fixed inputs until the DUT shows phase ph, bounded
  task automatic wait_phase(input int ph, input bit p);
    int n = 0;
    while (int'(phase) != ph && n < 200) begin
      step(0, 0, p);
      n++;
    end
    chk("wait_phase", 32'(phase), ph);
  endtask

  initial begin
    int       acks_in_red;
    bit       f_lvl;
    bit       r, p;
    logic [19:0] pat;

    reset = 1'b1; fault = 1'b0; ped_req = 1'b0;

    // Reset values
    step(1, 0, 0);
    chk("rst_red", 32'(red), 1);
    chk("rst_walk", 32'(walk), 1);
    chk("rst_dont_walk", 32'(dont_walk), 0);
    chk("rst_remaining", 32'(remaining), RT - 1);

    // Free run: 24 / 32 / 8 cycle phases
    wait_phase(1, 0);
    chk("free_red_len", last_len[0], 24);
    wait_phase(2, 0);
    chk("free_green_len", last_len[1], 32);
    wait_phase(0, 0);
    chk("free_yellow_len", last_len[2], 8);

    // Pedestrian pulse just after GREEN entry: green cut to 12 cycles
    wait_phase(1, 0);
    step(0, 0, 1);
    wait_phase(2, 0);
    chk("pulse_green_len", last_len[1], 12);
    wait_phase(0, 0);
    chk("pulse_yellow_len", last_len[2], 8);

    // Request held through RED: no ack in RED, green cut to 12
    wait_phase(1, 0);
    wait_phase(0, 0);
    acks_in_red = 0;
    while (int'(phase) == 0 && run < 100) begin
      step(0, 0, 1);
      if (int'(phase) == 0 && ped_ack) acks_in_red++;
    end
    chk("held_red_acks", acks_in_red, 0);
    wait_phase(2, 1);
    chk("held_green_len", last_len[1], 12);
    wait_phase(0, 0);

    // Request at green tick 6: green ends at tick 7 (28 cycles)
    wait_phase(1, 0);
    repeat (23) step(0, 0, 0);
    step(0, 0, 1);
    wait_phase(2, 0);
    chk("late_green_len", last_len[1], 28);

    // Fault mid-GREEN for 20 cycles
    wait_phase(1, 0);
    repeat (10) step(0, 0, 0);
    for (int i = 19; i >= 0; i--) begin
      step(0, 1, (i % 3) == 0);
      pat[i] = yellow;
    end
    chk("flash_pattern", 32'(pat), 32'(20'b1111_0000_1111_0000_1111));
    wait_phase(1, 0);
    chk("flash_len", last_len[3], 20);
    chk("post_flash_red_len", last_len[0], 24);

    // Reset mid-YELLOW with fault and ped_req also high
    wait_phase(2, 0);
    step(0, 0, 0);
    step(1, 1, 1);
    chk("rst_mid_red", 32'(red), 1);
    chk("rst_mid_walk", 32'(walk), 1);
    chk("rst_mid_phase", 32'(phase), 0);
    chk("rst_mid_remaining", 32'(remaining), 5);
    chk("rst_mid_ack", 32'(ped_ack), 0);
    step(0, 0, 0);

    // Random stimulus against the model
    f_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 699) == 0);
      if (!f_lvl && $urandom_range(0, 149) == 0) f_lvl = 1'b1;
      else if (f_lvl && $urandom_range(0, 14) == 0) f_lvl = 1'b0;
      p = ($urandom_range(0, 9) == 0);
      step(r, f_lvl, p);
    end
    repeat (5) step(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
